rom_uart_loader: RTL
====================

Name: rom_uart_loader

Overview:
- Boot-time writer for the instruction ROM of open_risc_v_soc; replaces simulation-only file preloading with a hardware load path.
- Receives a framed image over a UART RX line and writes 32-bit words sequentially into the ROM write port.
- Holds the core in reset until the image is complete, then releases it.
- Sits in the SoC top, between the external rx pin, the ROM write port and the core reset input.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 4).
- ADDR_W, 12, ROM word-address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active low.
- rx  input  1  UART line; idle high, asynchronous to clk.
- reload  input  1  one-cycle pulse; restarts loading from S_DONE or S_ERR.
- rom_we  output  1  ROM write enable, one-cycle pulse per word.
- rom_waddr  output  ADDR_W  ROM word address.
- rom_wdata  output  32  ROM write data.
- core_rst_n  output  1  core reset, active low; high only in S_DONE.
- load_done  output  1  image fully written.
- load_err  output  1  load aborted: framing error or bad count.

Behaviour:
- Reset (rst=0 at a clk edge): FSM=S_LEN0, UART RX idle, word index=0, byte index=0; rom_we=0, rom_waddr=0, rom_wdata=0, core_rst_n=0, load_done=0, load_err=0.
- rx passes through a 2-flop synchronizer, reset to 1. All sampling uses the synchronized value.
- UART RX, 8N1, LSB first:
  - Idle: waits for synchronized rx=0.
  - Start bit: resamples at CLKS_PER_BIT/2. If rx is 1, the start is a glitch and RX returns to idle with no error.
  - Data bits: sampled every CLKS_PER_BIT after that, 8 bits.
  - Stop bit: sampled one bit time after the last data bit. If 1, byte_valid pulses for one cycle. If 0, frame_err pulses for one cycle and the byte is discarded.
- Image format (host to loader): COUNT_L, COUNT_H (16-bit word count N, little-endian), then N words, each 4 bytes little-endian (byte0 = bits 7:0).
- FSM states:
  - S_LEN0: on byte_valid, latch count[7:0] and go to S_LEN1.
  - S_LEN1: on byte_valid, latch count[15:8]. If N==0 or N>DEPTH, go to S_ERR; otherwise go to S_DATA.
  - S_DATA: on each byte_valid, shift the byte into the assembly register at lane byte_idx and increment byte_idx (mod 4).
    - When the 4th byte arrives, the next cycle drives rom_we=1, rom_waddr=word_idx and rom_wdata=the assembled word. word_idx then increments.
    - After the write of word N-1, go to S_DONE in the same cycle rom_we is high.
  - S_DONE: load_done=1, core_rst_n=1. Further rx bytes are ignored. reload goes to S_LEN0 with core_rst_n=0 and load_done=0 on the next cycle, and clears word_idx, byte_idx and load_err.
  - S_ERR: load_err=1, core_rst_n=0. Further rx bytes are ignored. reload goes to S_LEN0 as above.
- frame_err in S_LEN0, S_LEN1 or S_DATA goes to S_ERR. In S_DONE and S_ERR it is ignored.
- reload in S_LEN0, S_LEN1 or S_DATA is ignored.
- rom_waddr and rom_wdata hold their last values when rom_we=0.
- Outputs are registered. rom_we is never high two cycles in a row.
- Maximum word count is DEPTH; N==DEPTH writes addresses 0..DEPTH-1 with no wrap.
- Reset mid-load: the partially assembled word is discarded, no further writes occur, and outputs return to reset values.
  - ROM contents already written are not cleared.
  - An rx frame already in progress is abandoned; RX resynchronizes on the next falling edge.

Test Plan (CLK_FREQ=1000000, BAUD=100000, i.e. 10 clocks/bit; ADDR_W=4):
- Normal load: send 02 00 93 00 00 00 13 01 10 00 -> rom_we pulses twice; (addr 0, 0x00000093), then (addr 1, 0x00100113); load_done=1 and core_rst_n=1 on the cycle after the second write; load_err=0.
- Framing error: send count 01 00 then a data byte with stop bit 0 -> load_err=1, no rom_we pulse, core_rst_n stays 0. A reload pulse followed by a valid 01 00 78 56 34 12 -> write (0, 0x12345678), then load_done=1.
- Bad count: send 00 00 -> S_ERR, load_err=1. Send 11 00 (17 > DEPTH=16) after reload -> load_err=1. Send 10 00 plus 16 words -> 16 writes at addr 0..15, load_done=1.
- Start glitch: drive rx low for 3 clocks mid-idle -> no byte, no error. A following valid image loads normally.
- Reset mid-load: assert rst after 2 of 4 bytes of word 1 -> all outputs return to reset values, no write to addr 1. After release, a fresh 01 00 EF BE AD DE -> write (0, 0xDEADBEEF).
- Bytes after done: send extra bytes in S_DONE -> no rom_we, core_rst_n stays 1. Bytes arriving in S_DONE or S_ERR without a reload -> no rom_we, state unchanged.

Source files
------------

// File: rtl/rom_uart_loader.sv
// Boot loader: receives a length-prefixed image over UART 8N1 and writes it word by word
// into the instruction ROM, holding the core in reset until the image is complete.
module rom_uart_loader #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              reload,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0]      DEPTH   = 17'(2 ** ADDR_W);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR} ld_state_t;

    logic             rx_meta_r, rx_sync_r;
    rx_state_t        rx_state_r, rx_state_s;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_bit_r;
    logic [7:0]       rx_shift_r;
    logic             rx_sample_s;
    logic             byte_valid_r, frame_err_r;

    ld_state_t        state_r, state_s;
    logic [15:0]      count_r, new_count_s, word_idx_r;
    logic [1:0]       byte_idx_r;
    logic [23:0]      asm_r;
    logic             latch_lo_s, latch_hi_s, take_byte_s, write_s, clear_s;
    logic             bad_count_s, last_word_s;

    logic              rom_we_r, core_rst_n_r, load_done_r, load_err_r;
    logic [ADDR_W-1:0] rom_waddr_r;
    logic [31:0]       rom_wdata_r;

    assign rom_we     = rom_we_r;
    assign rom_waddr  = rom_waddr_r;
    assign rom_wdata  = rom_wdata_r;
    assign core_rst_n = core_rst_n_r;
    assign load_done  = load_done_r;
    assign load_err   = load_err_r;

    // Two-flop synchronizer for the asynchronous rx pin, idling high
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // UART receiver next-state: start bit is checked at half a bit time to reject glitches
    always_comb begin
        rx_state_s  = rx_state_r;
        rx_sample_s = (rx_state_r == RX_START) ? (rx_cnt_r == HALF_M1) : (rx_cnt_r == FULL_M1);
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_sync_r) rx_state_s = RX_START;
                else            rx_state_s = RX_IDLE;
            end
            RX_START: begin
                if (rx_sample_s) rx_state_s = rx_sync_r ? RX_IDLE : RX_DATA;
                else             rx_state_s = RX_START;
            end
            RX_DATA: begin
                if (rx_sample_s && (rx_bit_r == 3'd7)) rx_state_s = RX_STOP;
                else                                   rx_state_s = RX_DATA;
            end
            RX_STOP: begin
                if (rx_sample_s) rx_state_s = RX_IDLE;
                else             rx_state_s = RX_STOP;
            end
            default: rx_state_s = RX_IDLE;
        endcase
    end

    // UART receiver state, bit timing and byte/frame-error strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_r   <= RX_IDLE;
            rx_cnt_r     <= '0;
            rx_bit_r     <= 3'd0;
            rx_shift_r   <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            rx_state_r   <= rx_state_s;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if ((rx_state_r == RX_IDLE) || rx_sample_s) rx_cnt_r <= '0;
            else                                       rx_cnt_r <= rx_cnt_r + CNT_W'(1);
            if (rx_state_r == RX_START) rx_bit_r <= 3'd0;
            if ((rx_state_r == RX_DATA) && rx_sample_s) begin
                rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                rx_bit_r   <= rx_bit_r + 3'd1;
            end
            if ((rx_state_r == RX_STOP) && rx_sample_s) begin
                byte_valid_r <= rx_sync_r;
                frame_err_r  <= !rx_sync_r;
            end
        end
    end

    assign new_count_s = {rx_shift_r, count_r[7:0]};
    assign bad_count_s = (new_count_s == 16'd0) || ({1'b0, new_count_s} > DEPTH);
    assign last_word_s = (word_idx_r == (count_r - 16'd1));

    // Loader next-state and datapath strobes
    always_comb begin
        state_s     = state_r;
        latch_lo_s  = 1'b0;
        latch_hi_s  = 1'b0;
        take_byte_s = 1'b0;
        write_s     = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            S_LEN0: begin
                if (frame_err_r) begin
                    state_s = S_ERR;
                end else if (byte_valid_r) begin
                    latch_lo_s = 1'b1;
                    state_s    = S_LEN1;
                end else begin
                    state_s = S_LEN0;
                end
            end
            S_LEN1: begin
                if (frame_err_r) begin
                    state_s = S_ERR;
                end else if (byte_valid_r) begin
                    latch_hi_s = 1'b1;
                    state_s    = bad_count_s ? S_ERR : S_DATA;
                end else begin
                    state_s = S_LEN1;
                end
            end
            S_DATA: begin
                if (frame_err_r) begin
                    state_s = S_ERR;
                end else if (byte_valid_r) begin
                    take_byte_s = 1'b1;
                    if (byte_idx_r == 2'd3) begin
                        write_s = 1'b1;
                        state_s = last_word_s ? S_DONE : S_DATA;
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    state_s = S_DATA;
                end
            end
            S_DONE, S_ERR: begin
                if (reload) begin
                    clear_s = 1'b1;
                    state_s = S_LEN0;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = S_LEN0;
        endcase
    end

    // Loader state, word assembly and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= S_LEN0;
            count_r      <= 16'd0;
            word_idx_r   <= 16'd0;
            byte_idx_r   <= 2'd0;
            asm_r        <= 24'd0;
            rom_we_r     <= 1'b0;
            rom_waddr_r  <= '0;
            rom_wdata_r  <= 32'd0;
            core_rst_n_r <= 1'b0;
            load_done_r  <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (latch_lo_s) count_r[7:0]  <= rx_shift_r;
            if (latch_hi_s) count_r[15:8] <= rx_shift_r;
            if (clear_s) begin
                word_idx_r <= 16'd0;
                byte_idx_r <= 2'd0;
            end else if (take_byte_s) begin
                byte_idx_r <= byte_idx_r + 2'd1;
                case (byte_idx_r)
                    2'd0:    asm_r[7:0]   <= rx_shift_r;
                    2'd1:    asm_r[15:8]  <= rx_shift_r;
                    2'd2:    asm_r[23:16] <= rx_shift_r;
                    default: asm_r        <= asm_r;
                endcase
                if (write_s) word_idx_r <= word_idx_r + 16'd1;
            end
            rom_we_r <= write_s;
            if (write_s) begin
                rom_waddr_r <= word_idx_r[ADDR_W-1:0];
                rom_wdata_r <= {rx_shift_r, asm_r};
            end
            // Done/core release follow the final write by one cycle but drop right after reload
            load_done_r  <= (state_r == S_DONE) && (state_s == S_DONE);
            core_rst_n_r <= (state_r == S_DONE) && (state_s == S_DONE);
            load_err_r   <= (state_s == S_ERR);
        end
    end

endmodule
